frame_reader_expand: RTL and testbench
======================================

# frame_reader_expand

Read side of the dithered frame buffer: walks the buffer in raster order in step with the VGA `visible` window and issues synchronous reads. It expands each stored RGB444 pixel, the 4-bit-per-channel words written after dithering, back to 8 bits per channel for the VGA output stage. It sits between the frame-buffer BRAM read port and the VGA pin registers, with a fixed 2-cycle pipeline latency.

## Interface
- `IMG_W`, 640: stored image width in pixels.
- `IMG_H`, 480: stored image height in lines.
- `ADDR_W`, 19: frame-buffer address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.

- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-high reset.
- `visible`  in  1  high during active video pixels, from the timing generator.
- `frame_start`  in  1  single-cycle pulse, issued once per frame during vertical blanking.
- `mem_addr`  out  ADDR_W  frame-buffer read address.
- `mem_rd_en`  out  1  read strobe.
- `mem_data`  in  12  {R[3:0],G[3:0],B[3:0]}, valid 1 cycle after `mem_rd_en`.
- `r_out`, `g_out`, `b_out`  out  8 each  expanded colour.
- `pix_valid`  out  1  `visible` delayed 2 cycles.
- `frame_overrun`  out  1  sticky flag: address wrapped inside a frame.

## Operation
- FSM with two states:
  - WAIT_FRAME, the reset state: no reads are issued and the outputs are black. Moves to ACTIVE on `frame_start`.
  - ACTIVE: stays in ACTIVE. A `frame_start` in ACTIVE restarts the frame.
- `frame_start` behaviour:
  - Sets the address counter to 0, `line_base` to 0 and `line_par` to 0.
  - Clears `frame_overrun`.
  - Has priority over `visible` in the same cycle. That cycle's read is suppressed.
- In ACTIVE with `visible`=1:
  - `mem_rd_en`=1 and `mem_addr` = the current counter value.
  - The counter then advances per the addressing rule.
- Wrap: an increment from IMG_W*IMG_H−1 goes to 0 and sets `frame_overrun`. The flag stays set until the next `frame_start` or `rst`.
- Expansion: each nibble n becomes {n,n}, so 0→0x00, 8→0x88, F→0xFF. No rounding or clipping is needed.
- When `pix_valid`=0, `r_out`/`g_out`/`b_out` are 0x00 regardless of `mem_data`.
- Without PIXEL_DOUBLE_EN:
  - The counter increments on every `visible` cycle.
  - Line boundaries need no special handling.

## Timing
- Cycle t: `visible`=1, `mem_addr`=A, `mem_rd_en`=1.
- Cycle t+1: `mem_data`=pixel A.
- Cycle t+2: registered `r_out`/`g_out`/`b_out` hold the expansion of A, and `pix_valid`=1.
- The timing generator delays hsync/vsync by 2 cycles to match.
- Reset values (asynchronous):
  - State = WAIT_FRAME.
  - `mem_addr`=0, `mem_rd_en`=0.
  - Colour outputs 0x00, `pix_valid`=0, `frame_overrun`=0.
  - Internal delay registers 0.
- Reset asserted mid-line:
  - Outputs go black immediately.
  - The block ignores `visible` until the next `frame_start`.
- `visible` falling edge is detected as the registered `visible` being 1 while the current `visible` is 0. It is used only in PIXEL_DOUBLE_EN builds.

## Configuration
- Macro: `PIXEL_DOUBLE_EN`.
- Defined: each stored pixel is shown as a 2×2 block (stored image IMG_W×IMG_H, display 2·IMG_W×2·IMG_H).
  - Column: a toggle bit advances the counter every second `visible` cycle, starting with the second.
  - At each `visible` falling edge:
    - If `line_par`=0, the counter is reloaded with `line_base`, so the same stored line repeats.
    - If `line_par`=1, `line_base` is set to the counter value.
    - Then `line_par` toggles and the column toggle is cleared.
  - The wrap and overrun rules are unchanged.
- Undefined: one memory pixel per display pixel. The `line_base` and `line_par` logic is not synthesized.

## Structure
- Shared package `vga_pkg` holds:
  - `rgb444_t` (packed struct r,g,b 4-bit) and `rgb888_t`.
  - Function `expand4to8`.
  - Default `IMG_W`/`IMG_H` constants, shared with the serial writer and the dither block.
- One sub-module, `fb_addr_gen`, contains the address counter, wrap/overrun logic and the PIXEL_DOUBLE_EN line logic. The top level holds the FSM, the delay pipeline and the expansion.

## Test plan
- Reset → `frame_start` → 4 visible cycles with BRAM model data 0x000, 0x8F1, 0xFFF, 0x123 at addresses 0..3 → addresses 0,1,2,3 issued. Output from cycle 3: (00,00,00), (88,FF,11), (FF,FF,FF), (11,22,33). `pix_valid` is high for exactly those 4 cycles.
- `visible` pulses before any `frame_start` after reset → `mem_rd_en` stays 0 and outputs stay 0x00.
- IMG_W=4, IMG_H=2, 9 visible cycles in one frame → addresses 0..7 then 0, and `frame_overrun`=1 from the wrap. The next `frame_start` clears it.
- `frame_start` coincident with `visible` → no read that cycle. The next visible cycle reads address 0.
- `rst` asserted mid-line with `pix_valid`=1 → all outputs 0 in the same cycle. Reads resume only after `frame_start`.
- PIXEL_DOUBLE_EN, IMG_W=2, two lines of 4 visible cycles, then two more lines → address sequences 0,0,1,1 / 0,0,1,1 / 2,2,3,3 / 2,2,3,3.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA pixel types, default image geometry and the RGB444 -> RGB888 expansion.
// Used by the frame reader, the serial writer and the dither block.
package vga_pkg;

    localparam int IMG_W_DEF  = 640;
    localparam int IMG_H_DEF  = 480;
    localparam int ADDR_W_DEF = 19;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } rd_state_e;

    // Replicating the nibble maps 0x0 -> 0x00 and 0xF -> 0xFF exactly.
    function automatic logic [7:0] expand4to8(input logic [3:0] n);
        return {n, n};
    endfunction

    function automatic rgb888_t expand_rgb(input rgb444_t p);
        rgb888_t o;
        o.r = expand4to8(p.r);
        o.g = expand4to8(p.g);
        o.b = expand4to8(p.b);
        return o;
    endfunction

endpackage

// File: rtl/frame_reader_expand_if.sv
// Frame-buffer read port: address and read strobe out, RGB444 word back one cycle later.
interface frame_reader_expand_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [11:0]       mem_data;

    modport master (output mem_addr, output mem_rd_en, input mem_data);
    modport slave  (input mem_addr, input mem_rd_en, output mem_data);
endinterface

// File: rtl/fb_addr_gen.sv
// Frame-buffer read address counter with wrap detection and sticky overrun flag.
// With PIXEL_DOUBLE_EN defined each stored pixel is read for a 2x2 display block.
module fb_addr_gen
    import vga_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
`ifdef PIXEL_DOUBLE_EN
    input  logic              line_end,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic              ovr_q, ovr_d, at_last_s;
`ifdef PIXEL_DOUBLE_EN
    logic              col_q, col_d, par_q, par_d;
    logic [ADDR_W-1:0] base_q, base_d;
`endif

    // Next counter value: clear beats advance; wrap at the last stored pixel.
    always_comb begin
        at_last_s = (cnt_q == LAST_ADDR);
        cnt_inc_s = at_last_s ? '0 : cnt_q + ADDR_W'(1);
        cnt_d     = cnt_q;
        ovr_d     = ovr_q;
`ifdef PIXEL_DOUBLE_EN
        col_d     = col_q;
        par_d     = par_q;
        base_d    = base_q;
`endif
        if (clear) begin
            cnt_d  = '0;
            ovr_d  = 1'b0;
`ifdef PIXEL_DOUBLE_EN
            base_d = '0;
            par_d  = 1'b0;
            col_d  = 1'b0;
`endif
        end else if (advance) begin
`ifdef PIXEL_DOUBLE_EN
            if (col_q) begin
                cnt_d = cnt_inc_s;
                ovr_d = ovr_q | at_last_s;
                col_d = 1'b0;
            end else begin
                col_d = 1'b1;
            end
`else
            cnt_d = cnt_inc_s;
            ovr_d = ovr_q | at_last_s;
`endif
        end
`ifdef PIXEL_DOUBLE_EN
        // Even display line replays the stored line; odd line commits the new start.
        else if (line_end) begin
            if (par_q) begin
                base_d = cnt_q;
            end else begin
                cnt_d = base_q;
            end
            par_d = ~par_q;
            col_d = 1'b0;
        end
`endif
        else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            ovr_q  <= 1'b0;
`ifdef PIXEL_DOUBLE_EN
            col_q  <= 1'b0;
            par_q  <= 1'b0;
            base_q <= '0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            ovr_q  <= ovr_d;
`ifdef PIXEL_DOUBLE_EN
            col_q  <= col_d;
            par_q  <= par_d;
            base_q <= base_d;
`endif
        end
    end

    assign addr    = cnt_q;
    assign overrun = ovr_q;

endmodule

// File: rtl/frame_reader_expand.sv
// Raster-order frame-buffer reader: issues reads during `visible` and expands RGB444 to RGB888
// with a fixed 2-cycle latency. Optional macro PIXEL_DOUBLE_EN enables 2x2 pixel doubling.
module frame_reader_expand
    import vga_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  visible,
    input  logic                  frame_start,
    frame_reader_expand_if.master mem,
    output logic [7:0]            r_out,
    output logic [7:0]            g_out,
    output logic [7:0]            b_out,
    output logic                  pix_valid,
    output logic                  frame_overrun
);

    rd_state_e         state_q, state_d;
    logic              rd_en_s;
    logic              rd_dly_q, rd_dly_d;
    logic              pix_valid_q, pix_valid_d;
    rgb888_t           rgb_q, rgb_d;
    logic [ADDR_W-1:0] addr_s;

    // Reads are issued only once a frame has started; a frame_start cycle never reads.
    always_comb begin
        state_d = state_q;
        rd_en_s = 1'b0;
        case (state_q)
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_d = ACTIVE;
                end else begin
                    state_d = WAIT_FRAME;
                end
            end
            ACTIVE: begin
                state_d = ACTIVE;
                if (visible && !frame_start) begin
                    rd_en_s = 1'b1;
                end else begin
                    rd_en_s = 1'b0;
                end
            end
            default: begin
                state_d = WAIT_FRAME;
                rd_en_s = 1'b0;
            end
        endcase
    end

    // Stage 1 tracks the outstanding read; stage 2 registers the expanded pixel or black.
    always_comb begin
        rd_dly_d    = rd_en_s;
        pix_valid_d = rd_dly_q;
        if (rd_dly_q) begin
            rgb_d = expand_rgb(rgb444_t'(mem.mem_data));
        end else begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_FRAME;
            rd_dly_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            rd_dly_q    <= rd_dly_d;
            pix_valid_q <= pix_valid_d;
            rgb_q       <= rgb_d;
        end
    end

`ifdef PIXEL_DOUBLE_EN
    logic vis_q, vis_d;
    logic line_end_s;

    always_comb begin
        vis_d      = visible;
        line_end_s = (state_q == ACTIVE) && vis_q && !visible;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vis_q <= 1'b0;
        end else begin
            vis_q <= vis_d;
        end
    end
`endif

    fb_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (frame_start),
        .advance  (rd_en_s),
`ifdef PIXEL_DOUBLE_EN
        .line_end (line_end_s),
`endif
        .addr     (addr_s),
        .overrun  (frame_overrun)
    );

    assign mem.mem_addr  = addr_s;
    assign mem.mem_rd_en = rd_en_s;
    assign r_out         = rgb_q.r;
    assign g_out         = rgb_q.g;
    assign b_out         = rgb_q.b;
    assign pix_valid     = pix_valid_q;

endmodule

// File: tb/tb_frame_reader_expand.sv
// Self-checking bench for frame_reader_expand: vector table, directed corner cases and
// randomized raster traffic against a frame-level reference model.
module tb_frame_reader_expand;

`ifdef PIXEL_DOUBLE_EN
    localparam int TW = 2;
    localparam int TH = 2;
`else
    localparam int TW = 4;
    localparam int TH = 2;
`endif
    localparam int AW   = 19;
    localparam int NPIX = TW * TH;

    logic       clk = 1'b0;
    logic       rst;
    logic       visible;
    logic       frame_start;
    logic [7:0] r_out, g_out, b_out;
    logic       pix_valid;
    logic       frame_overrun;

    frame_reader_expand_if #(.ADDR_W(AW)) bus ();

    frame_reader_expand #(
        .IMG_W  (TW),
        .IMG_H  (TH),
        .ADDR_W (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .visible       (visible),
        .frame_start   (frame_start),
        .mem           (bus),
        .r_out         (r_out),
        .g_out         (g_out),
        .b_out         (b_out),
        .pix_valid     (pix_valid),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    logic [11:0] mem_model [0:7];

    always_ff @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_data <= mem_model[bus.mem_addr[2:0]];
        end
    end

    int checks = 0;
    int errors = 0;
    int stepn  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual=%0h expected=%0h", nm, stepn, act, exp);
        end
    endtask

    // Reference model: frame active flag, next pixel index, overrun flag, and the two
    // most recent cycles' read records (pixel value captured at read time).
    bit          m_active;
    int          m_idx;
    bit          m_ovr;
    bit          h_rd [2];
    bit          h_dc [2];
    logic [11:0] h_dat [2];

    task automatic model_reset();
        m_active = 1'b0;
        m_idx    = 0;
        m_ovr    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            h_rd[i]  = 1'b0;
            h_dc[i]  = 1'b0;
            h_dat[i] = 12'h000;
        end
    endtask

    task automatic drive(input logic v, input logic fs);
        @(negedge clk);
        visible     = v;
        frame_start = fs;
        stepn++;
        #1;
    endtask

    task automatic step(input logic v, input logic fs);
        logic        exp_rd;
        logic [11:0] px;
        drive(v, fs);
        exp_rd = m_active && v && !fs;
        chk("rd_en", bus.mem_rd_en, exp_rd);
        if (exp_rd) chk("addr", bus.mem_addr, m_idx);
        if (!h_dc[1]) begin
            px = h_rd[1] ? h_dat[1] : 12'h000;
            chk("pix_valid", pix_valid, h_rd[1]);
            chk("r_out", r_out, 8'(px[11:8] * 17));
            chk("g_out", g_out, 8'(px[7:4] * 17));
            chk("b_out", b_out, 8'(px[3:0] * 17));
        end
        chk("overrun", frame_overrun, m_ovr);
        h_rd[1]  = h_rd[0];
        h_dc[1]  = h_dc[0];
        h_dat[1] = h_dat[0];
        h_rd[0]  = exp_rd;
        h_dc[0]  = m_active && v && fs;
        h_dat[0] = exp_rd ? mem_model[m_idx[2:0]] : 12'h000;
        if (fs) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_ovr    = 1'b0;
        end else if (exp_rd) begin
            if (m_idx == NPIX - 1) begin
                m_idx = 0;
                m_ovr = 1'b1;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic chk_black(input string tag);
        chk({tag, "_rd_en"}, bus.mem_rd_en, 1'b0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_pix_valid"}, pix_valid, 1'b0);
        chk({tag, "_rgb"}, {r_out, g_out, b_out}, 24'h000000);
        chk({tag, "_overrun"}, frame_overrun, 1'b0);
    endtask

`ifndef PIXEL_DOUBLE_EN
    typedef struct packed {
        logic        vis;
        logic        fs;
        logic        exp_rd;
        logic [3:0]  exp_addr;
        logic        exp_pv;
        logic [23:0] exp_rgb;
    } vec_t;

    vec_t tbl [8];
`endif

    initial begin
        #200000;
        $display("FAIL watchdog step %0d", stepn);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        visible     = 1'b0;
        frame_start = 1'b0;
        model_reset();
        mem_model[0] = 12'h000;
        mem_model[1] = 12'h8F1;
        mem_model[2] = 12'hFFF;
        mem_model[3] = 12'h123;
        mem_model[4] = 12'hA5C;
        mem_model[5] = 12'h3E7;
        mem_model[6] = 12'h0F0;
        mem_model[7] = 12'hD21;
        #3;
        chk_black("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

`ifdef PIXEL_DOUBLE_EN
        begin
            int exp_seq [16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};
            drive(1'b1, 1'b0);
            chk("pre_frame_rd_en", bus.mem_rd_en, 1'b0);
            drive(1'b0, 1'b1);
            for (int ln = 0; ln < 4; ln++) begin
                for (int c = 0; c < 4; c++) begin
                    drive(1'b1, 1'b0);
                    chk("dbl_rd_en", bus.mem_rd_en, 1'b1);
                    chk("dbl_addr", bus.mem_addr, exp_seq[ln * 4 + c]);
                end
                drive(1'b0, 1'b0);
                drive(1'b0, 1'b0);
            end
            chk("dbl_overrun", frame_overrun, 1'b1);
            drive(1'b0, 1'b1);
            drive(1'b0, 1'b0);
            chk("dbl_overrun_clear", frame_overrun, 1'b0);
        end
`else
        // Visible activity before any frame_start must not read or light the outputs.
        repeat (3) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);

        tbl[0] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 24'h000000};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 24'h000000};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 24'h000000};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 24'h000000};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 24'h88FF11};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 24'hFFFFFF};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 24'h112233};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 24'h000000};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].vis, tbl[i].fs);
            chk("tbl_rd_en", bus.mem_rd_en, tbl[i].exp_rd);
            if (tbl[i].exp_rd) chk("tbl_addr", bus.mem_addr, tbl[i].exp_addr);
            chk("tbl_pix_valid", pix_valid, tbl[i].exp_pv);
            chk("tbl_rgb", {r_out, g_out, b_out}, tbl[i].exp_rgb);
        end

        // Nine reads in an 8-pixel frame wrap to 0 and set the sticky overrun flag.
        step(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0);
            chk("wrap_addr", bus.mem_addr, i % NPIX);
        end
        step(1'b0, 1'b0);
        chk("wrap_overrun", frame_overrun, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("overrun_cleared", frame_overrun, 1'b0);

        // frame_start coincident with visible suppresses that read and restarts at 0.
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("fs_vis_rd_en", bus.mem_rd_en, 1'b0);
        step(1'b1, 1'b0);
        chk("fs_vis_next_addr", bus.mem_addr, 0);
        chk("fs_vis_next_rd", bus.mem_rd_en, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // Asynchronous reset mid-line blanks everything at once.
        step(1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        chk("pre_rst_pix_valid", pix_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_black("midline_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk("post_rst_addr", bus.mem_addr, 0);
        chk("post_rst_rd", bus.mem_rd_en, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // Randomized raster traffic with frame_start pulses in blanking.
        for (int i = 0; i < 8; i++) mem_model[i] = 12'($urandom);
        step(1'b0, 1'b1);
        begin
            logic v;
            logic fs;
            v = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 4) == 0) v = ~v;
                fs = !v && ($urandom_range(0, 30) == 0);
                step(v, fs);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
